fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 32 +++
 rtl/fetch_unit_inst_decoder.sv | 53 +++++
 rtl/fetch_unit.sv | 129 ++++++++++++
 tb/tb_fetch_unit.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the fetch unit: opcode and FSM state encodings plus the
// bit positions of each instruction field in the 9-bit instruction word.
package fetch_pkg;

  typedef enum logic [2:0] {
    OP_ALU  = 3'b000,
    OP_ACC  = 3'b001,
    OP_LD   = 3'b010,
    OP_ST   = 3'b011,
    OP_BR   = 3'b100,
    OP_JMP  = 3'b101,
    OP_NOP  = 3'b110,
    OP_HALT = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam int unsigned OP_MSB  = 8;
  localparam int unsigned OP_LSB  = 6;
  localparam int unsigned RS_MSB  = 5;
  localparam int unsigned RS_LSB  = 3;
  localparam int unsigned RT_MSB  = 2;
  localparam int unsigned RT_LSB  = 0;
  localparam int unsigned OFF_MSB = 5;
  localparam int unsigned OFF_W   = 6;

endpackage

// File: rtl/fetch_unit_inst_decoder.sv
// Combinational instruction decode: splits IR into register indices and
// opcode, and raises the control strobes only while the FSM is in EXEC.
module inst_decoder
  import fetch_pkg::*;
#(
  parameter int IW = 9,
  parameter int D  = 3
) (
  input  logic [IW-1:0] ir,
  input  logic          exec,
  output logic [D-1:0]  read_reg1,
  output logic [D-1:0]  read_reg2,
  output logic [2:0]    opcode,
  output logic          acc_read,
  output logic [1:0]    reg_write,
  output logic          mem_read,
  output logic          mem_write,
  output logic          is_br,
  output logic          is_jmp,
  output logic          is_halt
);

  opcode_t op;

  assign op = opcode_t'(ir[OP_MSB:OP_LSB]);

  // Field extraction is unconditional so indices hold with IR outside EXEC
  always_comb begin
    read_reg1 = ir[RS_MSB:RS_LSB];
    read_reg2 = ir[RT_MSB:RT_LSB];
    opcode    = op;
    acc_read  = 1'b0;
    reg_write = 2'b00;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    is_br     = 1'b0;
    is_jmp    = 1'b0;
    is_halt   = 1'b0;
    if (exec) begin
      case (op)
        OP_ALU:  reg_write = 2'b01;
        OP_ACC:  begin acc_read = 1'b1; reg_write = 2'b10; end
        OP_LD:   begin mem_read = 1'b1; reg_write = 2'b01; end
        OP_ST:   mem_write = 1'b1;
        OP_BR:   is_br = 1'b1;
        OP_JMP:  is_jmp = 1'b1;
        OP_HALT: is_halt = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch unit: IDLE/FETCH/EXEC/HALT sequencer, program counter, instruction
// register and retired-instruction counter. Each instruction takes one FETCH
// and one EXEC cycle. Optional macro FETCH_UNIT_STALL_EN adds a Stall input
// that freezes all state and suppresses write strobes.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int PW = 10,
  parameter int IW = 9,
  parameter int D  = 3
) (
  input  logic          CLK,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic          Taken,
`ifdef FETCH_UNIT_STALL_EN
  input  logic          Stall,
`endif
  output logic [PW-1:0] InstAddr,
  input  logic [IW-1:0] InstIn,
  output logic [D-1:0]  ReadReg1,
  output logic [D-1:0]  ReadReg2,
  output logic          AccRead,
  output logic [1:0]    RegWrite,
  output logic          MemRead,
  output logic          MemWrite,
  output logic [2:0]    Opcode,
  output logic          Done,
  output logic [15:0]   InstCount
);

  state_t        state, state_n;
  logic [PW-1:0] pc, pc_n;
  logic [IW-1:0] ir, ir_n;
  logic [15:0]   cnt, cnt_n;
  logic          stall;
  logic [PW-1:0] off_sext;
  logic          take;

  logic [1:0]    dec_reg_write;
  logic          dec_mem_read;
  logic          dec_mem_write;
  logic          is_br, is_jmp, is_halt;

`ifdef FETCH_UNIT_STALL_EN
  assign stall = Stall;
`else
  assign stall = 1'b0;
`endif

  inst_decoder #(
    .IW (IW),
    .D  (D)
  ) u_dec (
    .ir        (ir),
    .exec      (state == EXEC),
    .read_reg1 (ReadReg1),
    .read_reg2 (ReadReg2),
    .opcode    (Opcode),
    .acc_read  (AccRead),
    .reg_write (dec_reg_write),
    .mem_read  (dec_mem_read),
    .mem_write (dec_mem_write),
    .is_br     (is_br),
    .is_jmp    (is_jmp),
    .is_halt   (is_halt)
  );

  assign off_sext = {{(PW-OFF_W){ir[OFF_MSB]}}, ir[OFF_MSB:0]};
  assign take     = is_jmp | (is_br & Taken);

  // State, PC, IR and counter registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      state <= IDLE;
      pc    <= '0;
      ir    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      ir    <= ir_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state, next-PC, IR capture and saturating retire count
  always_comb begin
    state_n = state;
    pc_n    = pc;
    ir_n    = ir;
    cnt_n   = cnt;
    case (state)
      IDLE:  if (Start) state_n = FETCH;
      FETCH: begin
        state_n = EXEC;
        ir_n    = InstIn;
      end
      EXEC: begin
        state_n = is_halt ? HALT : FETCH;
        pc_n    = take ? pc + off_sext : pc + PW'(1);
        if (cnt != '1) cnt_n = cnt + 16'd1;
      end
      HALT: if (Start) begin
        state_n = FETCH;
        pc_n    = '0;
      end
      default: state_n = IDLE;
    endcase
    // Stall overrides every update; reset still wins in the register block
    if (stall) begin
      state_n = state;
      pc_n    = pc;
      ir_n    = ir;
      cnt_n   = cnt;
    end
  end

  // Output drive: write strobes masked while stalled
  always_comb begin
    InstAddr  = pc;
    Done      = (state == HALT);
    InstCount = cnt;
    RegWrite  = stall ? 2'b00 : dec_reg_write;
    MemRead   = stall ? 1'b0  : dec_mem_read;
    MemWrite  = stall ? 1'b0  : dec_mem_write;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational instruction ROM and an
// expectation queue checked after each clock step.
module tb_fetch_unit;

  localparam int PW = 10;
  localparam int IW = 9;
  localparam int D  = 3;

  localparam logic [8:0] I_NOP  = 9'b110_000_000;
  localparam logic [8:0] I_HALT = 9'b111_000_000;

  logic          CLK = 1'b0;
  logic          Reset_n;
  logic          Start;
  logic          Taken;
`ifdef FETCH_UNIT_STALL_EN
  logic          Stall;
`endif
  logic [PW-1:0] InstAddr;
  logic [IW-1:0] InstIn;
  logic [D-1:0]  ReadReg1, ReadReg2;
  logic          AccRead;
  logic [1:0]    RegWrite;
  logic          MemRead, MemWrite;
  logic [2:0]    Opcode;
  logic          Done;
  logic [15:0]   InstCount;

  logic [IW-1:0] rom [0:(1<<PW)-1];

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;

  exp_t sb[$];

  always #5 CLK = ~CLK;

  assign InstIn = rom[InstAddr];

  fetch_unit #(.PW(PW), .IW(IW), .D(D)) dut (
    .CLK       (CLK),
    .Reset_n   (Reset_n),
    .Start     (Start),
    .Taken     (Taken),
`ifdef FETCH_UNIT_STALL_EN
    .Stall     (Stall),
`endif
    .InstAddr  (InstAddr),
    .InstIn    (InstIn),
    .ReadReg1  (ReadReg1),
    .ReadReg2  (ReadReg2),
    .AccRead   (AccRead),
    .RegWrite  (RegWrite),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Opcode    (Opcode),
    .Done      (Done),
    .InstCount (InstCount)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic want(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] observe(input string tag);
    case (tag)
      "addr": return 32'(InstAddr);
      "rw":   return 32'(RegWrite);
      "mr":   return 32'(MemRead);
      "mw":   return 32'(MemWrite);
      "acc":  return 32'(AccRead);
      "rr1":  return 32'(ReadReg1);
      "rr2":  return 32'(ReadReg2);
      "op":   return 32'(Opcode);
      "done": return 32'(Done);
      "cnt":  return 32'(InstCount);
      default: return 'x;
    endcase
  endfunction

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.tag);
      n_assert++;
      assert (obs === e.v) else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic fill_rom();
    for (int i = 0; i < (1 << PW); i++) rom[i] = I_NOP;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    Start   = 1'b0;
    Taken   = 1'b0;
    step();
    step();
    Reset_n = 1'b1;
  endtask

  task automatic start_pulse();
    Start = 1'b1;
    step();
    Start = 1'b0;
  endtask

  initial begin
`ifdef FETCH_UNIT_STALL_EN
    Stall = 1'b0;
`endif
    fill_rom();

    // Reset state of every output
    Reset_n = 1'b0; Start = 1'b0; Taken = 1'b0;
    step(); step();
    want("addr", 0); want("rw", 0); want("mr", 0); want("mw", 0);
    want("acc", 0); want("rr1", 0); want("rr2", 0); want("op", 0);
    want("done", 0); want("cnt", 0);
    drain();
    Reset_n = 1'b1;

    // ALU instruction at 0, then HALT
    rom[0] = 9'b000_001_010;
    rom[1] = I_HALT;
    start_pulse();
    want("rw", 0); want("addr", 0); want("done", 0); drain();
    step();
    want("rw", 1); want("rr1", 1); want("rr2", 2); want("op", 0); want("mr", 0); drain();
    step();
    want("rw", 0); want("addr", 1); want("rr1", 1); want("rr2", 2); drain();
    step();
    want("op", 7); want("rw", 0); want("done", 0); drain();
    step();
    want("done", 1); want("cnt", 2); want("addr", 2); drain();
    start_pulse();
    want("addr", 0); want("done", 0); want("cnt", 2); drain();

    // NOP, HALT: Done after four cycles past Start
    do_reset();
    fill_rom();
    rom[1] = I_HALT;
    start_pulse();
    step(); step(); step();
    want("done", 0); want("op", 7); drain();
    step();
    want("done", 1); want("cnt", 2); drain();
    start_pulse();
    want("addr", 0); want("done", 0); want("cnt", 2); drain();

    // JMP +5 to a BR with offset -3, taken then not taken
    do_reset();
    fill_rom();
    rom[0] = 9'b101_000101;
    rom[5] = 9'b100_111101;
    rom[2] = I_HALT;
    rom[6] = I_HALT;
    Taken = 1'b1;
    start_pulse();
    step(); step();
    want("addr", 5); drain();
    step();
    want("op", 4); drain();
    step();
    want("addr", 2); drain();
    Taken = 1'b0;
    step(); step();
    want("done", 1); want("cnt", 3); drain();
    start_pulse();
    step(); step();
    want("addr", 5); drain();
    step(); step();
    want("addr", 6); want("cnt", 5); drain();

    // PC wrap 1023 -> 0 via NOP
    do_reset();
    fill_rom();
    rom[0] = 9'b101_111111;
    start_pulse();
    step(); step();
    want("addr", 1023); drain();
    step();
    want("op", 6); drain();
    step();
    want("addr", 0); drain();

    // JMP -4 at PC=2 wraps backwards to 1022
    do_reset();
    fill_rom();
    rom[2]    = 9'b101_111100;
    rom[1022] = I_HALT;
    start_pulse();
    repeat (5) step();
    want("op", 5); drain();
    step();
    want("addr", 1022); drain();
    step(); step();
    want("done", 1); want("cnt", 4); drain();

    // Zero-offset JMP re-executes itself
    do_reset();
    fill_rom();
    rom[0] = 9'b101_000000;
    start_pulse();
    step(); step();
    want("addr", 0); want("cnt", 1); drain();
    step(); step();
    want("addr", 0); want("cnt", 2); drain();

    // Reset asserted during EXEC of an LD
    do_reset();
    fill_rom();
    rom[1] = 9'b010_011_100;
    start_pulse();
    step(); step(); step();
    want("mr", 1); want("rw", 1); want("rr1", 3); want("rr2", 4); want("op", 2);
    want("cnt", 1); drain();
    Reset_n = 1'b0;
    step();
    want("addr", 0); want("mr", 0); want("rw", 0); want("mw", 0);
    want("rr1", 0); want("rr2", 0); want("op", 0); want("done", 0); want("cnt", 0);
    drain();
    Reset_n = 1'b1;
    step(); step();
    want("addr", 0); want("rw", 0); want("mr", 0); want("op", 0); drain();

    // ACC then ST with Start held high through FETCH/EXEC
    do_reset();
    fill_rom();
    rom[0] = 9'b001_101_110;
    rom[1] = 9'b011_010_001;
    rom[2] = I_HALT;
    Start = 1'b1;
    step();
    step();
    want("acc", 1); want("rw", 2); want("rr1", 5); want("rr2", 6); want("mw", 0); drain();
    step();
    want("addr", 1); want("acc", 0); want("rw", 0); drain();
    step();
    want("mw", 1); want("mr", 0); want("rw", 0); want("rr1", 2); want("rr2", 1); want("op", 3);
    drain();
    Start = 1'b0;
    step();
    want("mw", 0); want("addr", 2); drain();
    step(); step();
    want("done", 1); want("cnt", 3); drain();

`ifdef FETCH_UNIT_STALL_EN
    // Stall for three cycles during EXEC of ST
    do_reset();
    fill_rom();
    rom[0] = 9'b011_000_000;
    rom[1] = I_HALT;
    start_pulse();
    step();
    Stall = 1'b1;
    #1;
    want("mw", 0); want("cnt", 0); drain();
    step();
    want("mw", 0); want("cnt", 0); want("addr", 0); drain();
    step();
    want("mw", 0); want("cnt", 0); want("addr", 0); drain();
    step();
    want("mw", 0); want("cnt", 0); want("addr", 0); drain();
    Stall = 1'b0;
    #1;
    want("mw", 1); want("cnt", 0); drain();
    step();
    want("mw", 0); want("addr", 1); want("cnt", 1); want("done", 0); drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
